// File: rtl/proj_pkg.sv
// Shared widths, counts and state types for the GFM pipeline stages.
package proj_pkg;

  localparam int EXTENDER_OUT_PART_LEN_ONE_HOT = 32;
  localparam int GFM_PARTS_COUNT = 8;
  localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
  localparam int SIGNED_INDICE_LEN = 16;
  localparam int ONE_HOT_LEN = 4;
  localparam int SCORER_SCORE_BITS =
    $clog2(EXTENDER_OUT_PART_LEN_ONE_HOT * GFM_PARTS_COUNT
           / ONE_HOT_LEN + 1);

  typedef enum logic [1:0] {
    SC_IDLE,
    SC_SCORE,
    SC_DONE
  } scorer_state_t;

endpackage

// File: rtl/proj_popcount.sv
// Combinational population count over a WIDTH-bit vector.
module proj_popcount #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         bits,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int CW = $clog2(WIDTH + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/proj_gfm_scorer.sv
// Scores streamed candidate fragments against a stored one-hot read
// and reports the best candidate index and matched-base count.
module proj_gfm_scorer
  import proj_pkg::*;
#(
  parameter int PART_ONE_HOT = EXTENDER_OUT_PART_LEN_ONE_HOT,
  parameter int PARTS_COUNT = GFM_PARTS_COUNT,
  parameter int CANDIDATES = SORTER_EXTENDER_INDICES_COUNT,
  parameter int IDX_LEN = SIGNED_INDICE_LEN,
  parameter int OH_LEN = ONE_HOT_LEN,
  parameter int READ_ONE_HOT = PART_ONE_HOT * PARTS_COUNT,
  parameter int SCORE_BITS = $clog2(READ_ONE_HOT / OH_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_start,
  input  logic [READ_ONE_HOT-1:0] in_read_gfm,
  input  logic                    in_valid,
  input  logic [PART_ONE_HOT-1:0] in_gfm,
  input  logic [IDX_LEN-1:0]      in_index,
  output logic                    out_valid,
  output logic [IDX_LEN-1:0]      out_best_index,
  output logic [SCORE_BITS-1:0]   out_best_score,
  output logic                    out_busy
);

  localparam int PART_BITS = $clog2(PART_ONE_HOT + 1);
  localparam int PI_W = $clog2(PARTS_COUNT);
  localparam int CI_W = $clog2(CANDIDATES);

  scorer_state_t state, state_nx;

  logic [READ_ONE_HOT-1:0] read_r;
  logic [PI_W-1:0]         part_idx;
  logic [CI_W-1:0]         cand_idx;
  logic [SCORE_BITS-1:0]   acc;
  logic [SCORE_BITS-1:0]   best_score;
  logic [IDX_LEN-1:0]      best_idx;

  logic [PART_ONE_HOT-1:0] read_part;
  logic [PART_ONE_HOT-1:0] match_bits;
  logic [PART_BITS-1:0]    part_score;
  logic [SCORE_BITS-1:0]   total;
  logic [SCORE_BITS-1:0]   nb_score;
  logic [IDX_LEN-1:0]      nb_idx;
  logic                    accept;
  logic                    last_part;
  logic                    last_cand;

  assign read_part = read_r[part_idx*PART_ONE_HOT +: PART_ONE_HOT];
  assign match_bits = in_gfm & read_part;

  proj_popcount #(
    .WIDTH(PART_ONE_HOT)
  ) u_pop (
    .bits (match_bits),
    .count(part_score)
  );

  assign total = acc + SCORE_BITS'(part_score);
  assign last_part = (part_idx == PI_W'(PARTS_COUNT - 1));
  assign last_cand = (cand_idx == CI_W'(CANDIDATES - 1));
  assign accept = (state == SC_SCORE) && in_valid && !in_start;

  // Strict compare: the earliest candidate keeps a tie.
  assign nb_score = (total > best_score) ? total : best_score;
  assign nb_idx = (total > best_score) ? in_index : best_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= SC_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SC_IDLE:  if (in_start) state_nx = SC_SCORE;
      SC_SCORE: begin
        if (in_start)
          state_nx = SC_SCORE;
        else if (accept && last_part && last_cand)
          state_nx = SC_DONE;
      end
      SC_DONE:  state_nx = in_start ? SC_SCORE : SC_IDLE;
      default:  state_nx = SC_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == SC_DONE);
    out_busy = (state == SC_SCORE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_r <= '0;
      part_idx <= '0;
      cand_idx <= '0;
      acc <= '0;
      best_score <= '0;
      best_idx <= '0;
      out_best_index <= '0;
      out_best_score <= '0;
    end else begin
      unique case (1'b1)
        in_start: begin
          read_r <= in_read_gfm;
          part_idx <= '0;
          cand_idx <= '0;
          acc <= '0;
          best_score <= '0;
          best_idx <= '0;
        end
        accept && last_part: begin
          best_score <= nb_score;
          best_idx <= nb_idx;
          acc <= '0;
          part_idx <= '0;
          cand_idx <= cand_idx + 1'b1;
          if (last_cand) begin
            out_best_index <= nb_idx;
            out_best_score <= nb_score;
          end
        end
        accept && !last_part: begin
          acc <= total;
          part_idx <= part_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proj_gfm_scorer.sv
// Randomized self-checking bench for proj_gfm_scorer with a
// base-level reference model.
module tb_proj_gfm_scorer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_start;
  logic [255:0] in_read_gfm;
  logic         in_valid;
  logic [31:0]  in_gfm;
  logic [15:0]  in_index;
  logic         out_valid;
  logic [15:0]  out_best_index;
  logic [6:0]   out_best_score;
  logic         out_busy;

  int tests = 0;
  int fails = 0;

  logic [255:0] c_frag[4];
  logic [15:0]  c_idx[4];

  proj_gfm_scorer dut (
    .clk           (clk),
    .rst           (rst),
    .in_start      (in_start),
    .in_read_gfm   (in_read_gfm),
    .in_valid      (in_valid),
    .in_gfm        (in_gfm),
    .in_index      (in_index),
    .out_valid     (out_valid),
    .out_best_index(out_best_index),
    .out_best_score(out_best_score),
    .out_busy      (out_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_read(input int n_pct);
    logic [255:0] r;
    r = '0;
    for (int b = 0; b < 64; b++) begin
      if (32'($urandom_range(99)) < n_pct) r[b*4 +: 4] = 4'b0000;
      else r[b*4 +: 4] = 4'b0001 << $urandom_range(3);
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_frag(input logic [255:0] rd);
    logic [255:0] f;
    f = '0;
    for (int b = 0; b < 64; b++) begin
      if ($urandom_range(1) == 1) f[b*4 +: 4] = rd[b*4 +: 4];
      else f[b*4 +: 4] = 4'b0001 << $urandom_range(3);
    end
    return f;
  endfunction

  // First k non-N bases copy the read, all others deliberately differ.
  function automatic logic [255:0] make_frag(input logic [255:0] rd,
                                             input int k);
    logic [255:0] f;
    logic [3:0] rb;
    int m;
    f = '0;
    m = 0;
    for (int b = 0; b < 64; b++) begin
      rb = rd[b*4 +: 4];
      if (m < k && rb != 4'b0000) begin
        f[b*4 +: 4] = rb;
        m++;
      end else if (rb == 4'b0000) begin
        f[b*4 +: 4] = 4'b0001;
      end else begin
        f[b*4 +: 4] = {rb[2:0], rb[3]};
      end
    end
    return f;
  endfunction

  function automatic int model_score(input logic [255:0] rd,
                                     input logic [255:0] f);
    int s;
    s = 0;
    for (int b = 0; b < 64; b++)
      if (rd[b*4 +: 4] != 4'b0000 && rd[b*4 +: 4] == f[b*4 +: 4]) s++;
    return s;
  endfunction

  task automatic model_best(input logic [255:0] rd,
                            output logic [15:0] bi, output int bs);
    int s;
    bi = '0;
    bs = 0;
    for (int c = 0; c < 4; c++) begin
      s = model_score(rd, c_frag[c]);
      if (s > bs) begin
        bs = s;
        bi = c_idx[c];
      end
    end
  endtask

  // Caller sits at a negedge; returns at a negedge.
  task automatic run_read(input logic [255:0] rd, input int stall,
                          input bit chain,
                          output logic [15:0] oi, output logic [6:0] os,
                          output bit lat_ok, output int pulses,
                          output bit busy_ok);
    int n;
    int guard;
    n = 0;
    guard = 0;
    pulses = 0;
    busy_ok = 1'b1;
    in_start = 1'b1;
    in_read_gfm = rd;
    in_valid = 1'b0;
    @(negedge clk);
    in_start = 1'b0;
    in_read_gfm = {8{$urandom}};
    while (n < 32 && guard < 2000) begin
      guard++;
      if (out_valid) pulses++;
      if (!out_busy) busy_ok = 1'b0;
      if (32'($urandom_range(99)) < stall) begin
        in_valid = 1'b0;
        in_gfm = $urandom;
        in_index = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        in_gfm = c_frag[n/8][(n%8)*32 +: 32];
        in_index = c_idx[n/8];
        n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (n < 32) begin
      tests++;
      fails++;
      $display("FAIL stream_timeout parts %0d of 32", n);
    end
    lat_ok = out_valid;
    if (out_valid) pulses++;
    oi = out_best_index;
    os = out_best_score;
    if (!chain) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({out_valid, out_busy} !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags got %b exp 00", {out_valid, out_busy});
    end
    tests++;
    if (out_best_index !== 16'd0 || out_best_score !== 7'd0) begin
      fails++;
      $display("FAIL reset_outs got %0h/%0d exp 0/0",
               out_best_index, out_best_score);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({out_valid, out_busy} !== 2'b00) begin
      fails++;
      $display("FAIL idle_flags got %b exp 00", {out_valid, out_busy});
    end
  endtask

  task automatic test_best_middle();
    logic [255:0] rd;
    logic [15:0] oi;
    logic [6:0] os;
    bit lat_ok, busy_ok;
    int pulses;
    rd = {64{4'b0001}};
    c_frag[0] = make_frag(rd, 2);  c_idx[0] = 16'd10;
    c_frag[1] = make_frag(rd, 64); c_idx[1] = 16'd20;
    c_frag[2] = make_frag(rd, 5);  c_idx[2] = 16'd30;
    c_frag[3] = make_frag(rd, 0);  c_idx[3] = 16'd40;
    run_read(rd, 0, 1'b0, oi, os, lat_ok, pulses, busy_ok);
    tests++;
    if (lat_ok !== 1'b1) begin
      fails++;
      $display("FAIL mid_latency got %b exp 1", lat_ok);
    end
    tests++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL mid_pulses got %0d exp 1", pulses);
    end
    tests++;
    if (busy_ok !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy got %b exp 1", busy_ok);
    end
    tests++;
    if (oi !== 16'd20 || os !== 7'd64) begin
      fails++;
      $display("FAIL mid_result got %0d/%0d exp 20/64", oi, os);
    end
  endtask

  task automatic test_tie_stall();
    logic [255:0] rd;
    logic [15:0] oi0, oi1;
    logic [6:0] os0, os1;
    bit lat_ok, busy_ok;
    int p0, p1;
    rd = rand_read(0);
    c_frag[0] = make_frag(rd, 7); c_idx[0] = 16'hFFFB;
    c_frag[1] = make_frag(rd, 7); c_idx[1] = 16'd9;
    c_frag[2] = make_frag(rd, 3); c_idx[2] = 16'd1;
    c_frag[3] = make_frag(rd, 7); c_idx[3] = 16'd2;
    run_read(rd, 0, 1'b0, oi0, os0, lat_ok, p0, busy_ok);
    run_read(rd, 30, 1'b0, oi1, os1, lat_ok, p1, busy_ok);
    tests++;
    if (oi0 !== 16'hFFFB || os0 !== 7'd7) begin
      fails++;
      $display("FAIL tie_nostall got %0h/%0d exp fffb/7", oi0, os0);
    end
    tests++;
    if (oi1 !== 16'hFFFB || os1 !== 7'd7) begin
      fails++;
      $display("FAIL tie_stall got %0h/%0d exp fffb/7", oi1, os1);
    end
    tests++;
    if (p1 !== 1 || lat_ok !== 1'b1) begin
      fails++;
      $display("FAIL tie_stall_pulse got %0d/%b exp 1/1", p1, lat_ok);
    end
  endtask

  task automatic test_n_mask();
    logic [255:0] rd;
    logic [15:0] oi;
    logic [6:0] os;
    bit lat_ok, busy_ok;
    int pulses;
    rd = {64{4'b0001}};
    for (int b = 0; b < 64; b += 8) rd[b*4 +: 4] = 4'b0000;
    c_frag[0] = make_frag(rd, 10);
    c_frag[1] = {64{4'b0001}};
    c_frag[2] = make_frag(rd, 30);
    c_frag[3] = make_frag(rd, 56);
    for (int c = 0; c < 4; c++) c_idx[c] = 16'(100 + c);
    run_read(rd, 10, 1'b0, oi, os, lat_ok, pulses, busy_ok);
    tests++;
    if (oi !== 16'd101 || os !== 7'd56) begin
      fails++;
      $display("FAIL n_mask got %0d/%0d exp 101/56", oi, os);
    end
  endtask

  task automatic test_abort();
    logic [255:0] rd0, rd1, junk;
    logic [15:0] oi;
    logic [6:0] os;
    bit lat_ok, busy_ok;
    int pulses;
    int early;
    rd0 = rand_read(0);
    junk = make_frag(rd0, 64);
    early = 0;
    in_start = 1'b1;
    in_read_gfm = rd0;
    @(negedge clk);
    in_start = 1'b0;
    for (int p = 0; p < 13; p++) begin
      in_valid = 1'b1;
      in_gfm = junk[(p%8)*32 +: 32];
      in_index = 16'd99;
      @(negedge clk);
      if (out_valid) early++;
    end
    in_valid = 1'b0;
    rd1 = rand_read(0);
    c_frag[0] = make_frag(rd1, 10); c_idx[0] = 16'd3;
    c_frag[1] = make_frag(rd1, 40); c_idx[1] = 16'd7;
    c_frag[2] = make_frag(rd1, 20); c_idx[2] = 16'd11;
    c_frag[3] = make_frag(rd1, 40); c_idx[3] = 16'd15;
    run_read(rd1, 0, 1'b0, oi, os, lat_ok, pulses, busy_ok);
    tests++;
    if (pulses + early !== 1) begin
      fails++;
      $display("FAIL abort_pulses got %0d exp 1", pulses + early);
    end
    tests++;
    if (oi !== 16'd7 || os !== 7'd40) begin
      fails++;
      $display("FAIL abort_result got %0d/%0d exp 7/40", oi, os);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] ra, rb;
    logic [15:0] oi, ei;
    logic [6:0] os;
    int es;
    bit lat_ok, busy_ok;
    int pulses;
    ra = rand_read(5);
    for (int c = 0; c < 4; c++) begin
      c_frag[c] = rand_frag(ra);
      c_idx[c] = 16'($urandom);
    end
    model_best(ra, ei, es);
    run_read(ra, 0, 1'b1, oi, os, lat_ok, pulses, busy_ok);
    tests++;
    if (oi !== ei || os !== 7'(es) || lat_ok !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first got %0h/%0d/%b exp %0h/%0d/1",
               oi, os, lat_ok, ei, es);
    end
    rb = rand_read(5);
    for (int c = 0; c < 4; c++) begin
      c_frag[c] = rand_frag(rb);
      c_idx[c] = 16'($urandom);
    end
    model_best(rb, ei, es);
    run_read(rb, 15, 1'b0, oi, os, lat_ok, pulses, busy_ok);
    tests++;
    if (oi !== ei || os !== 7'(es) || pulses !== 1) begin
      fails++;
      $display("FAIL b2b_second got %0h/%0d/%0d exp %0h/%0d/1",
               oi, os, pulses, ei, es);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] rd;
    int seen;
    int busy_seen;
    rd = rand_read(0);
    in_start = 1'b1;
    in_read_gfm = rd;
    @(negedge clk);
    in_start = 1'b0;
    for (int p = 0; p < 10; p++) begin
      in_valid = 1'b1;
      in_gfm = make_frag(rd, 64) >> ((p%8)*32);
      in_index = 16'd55;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({out_valid, out_busy} !== 2'b00) begin
      fails++;
      $display("FAIL rstmid_flags got %b exp 00", {out_valid, out_busy});
    end
    tests++;
    if (out_best_index !== 16'd0 || out_best_score !== 7'd0) begin
      fails++;
      $display("FAIL rstmid_outs got %0h/%0d exp 0/0",
               out_best_index, out_best_score);
    end
    seen = 0;
    busy_seen = 0;
    for (int p = 0; p < 40; p++) begin
      in_valid = 1'b1;
      in_gfm = $urandom;
      in_index = 16'($urandom);
      @(negedge clk);
      if (out_valid) seen++;
      if (out_busy) busy_seen++;
    end
    in_valid = 1'b0;
    tests++;
    if (seen !== 0 || busy_seen !== 0) begin
      fails++;
      $display("FAIL rstmid_idle got %0d/%0d exp 0/0", seen, busy_seen);
    end
  endtask

  task automatic test_random();
    logic [255:0] rd;
    logic [15:0] oi, ei;
    logic [6:0] os;
    int es;
    bit lat_ok, busy_ok;
    int pulses;
    for (int r = 0; r < 8; r++) begin
      rd = rand_read(10);
      for (int c = 0; c < 4; c++) begin
        c_frag[c] = rand_frag(rd);
        c_idx[c] = 16'($urandom);
      end
      if (r == 7) for (int c = 0; c < 4; c++) c_frag[c] = make_frag(rd, 0);
      model_best(rd, ei, es);
      run_read(rd, 20, 1'b0, oi, os, lat_ok, pulses, busy_ok);
      tests++;
      if (oi !== ei || os !== 7'(es) || pulses !== 1) begin
        fails++;
        $display("FAIL random_%0d got %0h/%0d/%0d exp %0h/%0d/1",
                 r, oi, os, pulses, ei, es);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_start = 1'b0;
    in_read_gfm = '0;
    in_valid = 1'b0;
    in_gfm = '0;
    in_index = '0;
    test_reset();
    test_best_middle();
    test_tie_stall();
    test_n_mask();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
